stream_sink_checker: RTL and testbench
======================================

# stream_sink_checker

Valid/ready stream sink that terminates the byte stream produced by the team's data source in the `buf/sync` test fabric. It accepts exactly N beats, checks each against an arithmetic expected sequence, and reports completion and mismatches through sticky status outputs. An optional compiled-in backpressure pattern throttles `in_ready` so benches can exercise source stall behaviour.

## Interface

- `DATA_WIDTH`, 8, beat width
- `N`, 4, beats to accept before completion (N ≥ 1)
- `EXP_BASE`, 8'h11, expected value of beat 0
- `EXP_STEP`, 8'h11, increment between expected beats, modulo 2^DATA_WIDTH
- `STALL_PATTERN`, 8'b1011_0110, ready pattern; bit k = ready in pattern slot k; used only with `SINK_STALL_EN`
- `CW`, derived: $clog2(N+1), counter width

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_WIDTH  beat payload
- `in_valid`  in  1  beat present
- `in_ready`  out  1  sink accepts; registered
- `rx_count`  out  CW  beats accepted so far
- `mism_count`  out  CW  beats that mismatched
- `error`  out  1  sticky, set on first mismatch
- `first_err_idx`  out  CW  index of first mismatching beat
- `first_err_data`  out  DATA_WIDTH  payload of first mismatching beat
- `last_data`  out  DATA_WIDTH  payload of most recent accepted beat
- `done`  out  1  N beats accepted; sticky until reset

## Operation

- Transfer: a beat is accepted on a rising edge where `in_valid` and `in_ready` are both 1. No other edge changes counters or captured data.
- FSM, 2 states: RECV (reset state), DONE.
  - RECV: accept beats. Accepting with `rx_count == N-1` → DONE.
  - DONE: `in_ready` held 0, `done` = 1, `in_valid`/`in_data` ignored. Exits only via reset.
- Expected value register `exp`: resets to `EXP_BASE`; on each accept `exp <= exp + EXP_STEP` (wraps at DATA_WIDTH bits, no carry out).
- On accept: `rx_count` +1; `last_data <= in_data`; if `in_data != exp` then `mism_count` +1, and, if `error` is 0, `error <= 1`, `first_err_idx <= rx_count` (pre-increment), `first_err_data <= in_data`.
- Later mismatches leave `first_err_*` untouched. Counters cannot exceed N (acceptance stops in DONE), so no saturation is needed.
- Reset values: `in_ready` 0, `rx_count` 0, `mism_count` 0, `error` 0, `first_err_idx` 0, `first_err_data` 0, `last_data` 0, `done` 0, `exp` = `EXP_BASE`, state RECV.
- Reset asserted mid-stream: all state returns to reset values immediately, regardless of `clk`. Partial results are discarded.

## Timing

- `in_ready` is a registered output. It is 0 during reset and for the first edge after `rst_n` rises, and takes its RECV value from the first rising edge onward.
- On the edge accepting beat N-1, `in_ready <= 0` and `done <= 1` together. Beat N-1 is the last accepted beat; no extra beat slips through.
- Status outputs update on the accepting edge and are valid the following cycle. Latency from accept to visible status is 1 cycle.
- `in_valid` with `in_ready` 0 has no effect; data is neither captured nor checked.
- Max throughput is 1 beat/cycle when no stall is compiled in.

## Configuration

- `SINK_STALL_EN` defined:
  - A 3-bit slot pointer resets to 0 and advances by 1 (mod 8) on every rising edge while in RECV, whether or not a beat is accepted.
  - In RECV, `in_ready <= STALL_PATTERN[ptr]`. In DONE the pointer freezes and `in_ready` is 0.
- `SINK_STALL_EN` undefined: no pointer. In RECV, `in_ready <= 1`; in DONE, 0.

## Test plan

- Reset, stall off; source drives 8'h11, 8'h22, 8'h33, 8'h44 back-to-back → 4 accepts on consecutive edges; `done`=1; `rx_count`=4; `error`=0; `last_data`=8'h44; `in_ready`=0 afterwards.
- Beat 2 driven as 8'h35 → `error`=1; `mism_count`=1; `first_err_idx`=2; `first_err_data`=8'h35; `done` still 1 after beat 3.
- Beats 1 and 3 wrong (8'h00, 8'hFF) → `mism_count`=2; `first_err_idx`=1; `first_err_data`=8'h00.
- `SINK_STALL_EN`, default pattern, `in_valid` held 1 → accepts only on cycles where the pattern slot is 1; all 4 beats correct; no beat is duplicated or dropped.
- `rst_n` pulsed low after 2 accepts → all outputs return to reset values asynchronously; a fresh 4-beat sequence completes with `rx_count`=4 and `error`=0.
- After `done`, hold `in_valid`=1 with 8'h55 for 10 cycles → `rx_count`, `last_data` and `mism_count` unchanged; `in_ready` stays 0.

Source files
------------

// File: rtl/stream_sink_checker.sv
// stream_sink_checker
// Valid/ready byte-stream sink. It accepts exactly N beats and checks each one
// against the arithmetic sequence EXP_BASE + k*EXP_STEP. Completion and
// mismatches are reported through sticky status outputs.
//
// Optional feature macro: SINK_STALL_EN. When it is defined, in_ready follows
// STALL_PATTERN, indexed by a free-running 3-bit slot pointer while in RECV.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_data        beat payload
//   in_valid       beat present
//   in_ready       sink accepts (registered)
//   rx_count       beats accepted so far
//   mism_count     beats that mismatched
//   error          sticky, set on first mismatch
//   first_err_idx  index of first mismatching beat
//   first_err_data payload of first mismatching beat
//   last_data      payload of most recent accepted beat
//   done           N beats accepted; sticky until reset
module stream_sink_checker #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           N             = 4,
  parameter logic [DATA_WIDTH-1:0] EXP_BASE      = 8'h11,
  parameter logic [DATA_WIDTH-1:0] EXP_STEP      = 8'h11,
  parameter logic [7:0]            STALL_PATTERN = 8'b1011_0110
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(N+1)-1:0]   rx_count,
  output logic [$clog2(N+1)-1:0]   mism_count,
  output logic                     error,
  output logic [$clog2(N+1)-1:0]   first_err_idx,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic [DATA_WIDTH-1:0]    last_data,
  output logic                     done
);

  localparam int unsigned CW = $clog2(N+1);

  typedef enum logic [0:0] {RECV = 1'b0, DONE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [CW-1:0]         rx_count_q, rx_count_d;
  logic [CW-1:0]         mism_count_q, mism_count_d;
  logic                  error_q, error_d;
  logic [CW-1:0]         first_err_idx_q, first_err_idx_d;
  logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;

  logic accept;
  logic last_beat;
  logic mismatch;

  // in_ready_q is only ever 1 in RECV; the state term guards against misuse
  assign accept    = in_valid && in_ready_q && (state_q == RECV);
  assign last_beat = (rx_count_q == CW'(N - 1));
  assign mismatch  = (in_data != exp_q);

`ifdef SINK_STALL_EN
  logic [2:0] ptr_q, ptr_d;

  // Slot pointer: advances every edge in RECV, freezes in DONE
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RECV) begin
      ptr_d = ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_d_hold: ptr_q <= ptr_d;
    end
  end
`else
  localparam logic [7:0] unused_stall_pattern = STALL_PATTERN;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave RECV on accepting the final beat; DONE is terminal
  always_comb begin
    state_d = state_q;
    if ((state_q == RECV) && accept && last_beat) begin
      state_d = DONE;
    end
  end

  // Output / datapath next values
  always_comb begin
    in_ready_d       = 1'b0;
    rx_count_d       = rx_count_q;
    mism_count_d     = mism_count_q;
    error_d          = error_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    last_data_d      = last_data_q;
    exp_d            = exp_q;
    done_d           = (state_d == DONE);

    // Ready is computed from the next state, so it drops on the final accept edge
    if (state_d == RECV) begin
`ifdef SINK_STALL_EN
      in_ready_d = STALL_PATTERN[ptr_q];
`else
      in_ready_d = 1'b1;
`endif
    end

    if (accept) begin
      rx_count_d  = rx_count_q + CW'(1);
      last_data_d = in_data;
      exp_d       = exp_q + EXP_STEP;
      if (mismatch) begin
        mism_count_d = mism_count_q + CW'(1);
        if (!error_q) begin
          error_d          = 1'b1;
          first_err_idx_d  = rx_count_q;
          first_err_data_d = in_data;
        end
      end
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q       <= 1'b0;
      rx_count_q       <= '0;
      mism_count_q     <= '0;
      error_q          <= 1'b0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      last_data_q      <= '0;
      done_q           <= 1'b0;
      exp_q            <= EXP_BASE;
    end else begin
      in_ready_q       <= in_ready_d;
      rx_count_q       <= rx_count_d;
      mism_count_q     <= mism_count_d;
      error_q          <= error_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      last_data_q      <= last_data_d;
      done_q           <= done_d;
      exp_q            <= exp_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign rx_count       = rx_count_q;
  assign mism_count     = mism_count_q;
  assign error          = error_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign last_data      = last_data_q;
  assign done           = done_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed self-checking bench for stream_sink_checker (N=4, base/step 8'h11).
module tb_stream_sink_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rx_count;
  logic [2:0] mism_count;
  logic       error;
  logic [2:0] first_err_idx;
  logic [7:0] first_err_data;
  logic [7:0] last_data;
  logic       done;

  int tests;
  int failed;

  stream_sink_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rx_count       (rx_count),
    .mism_count     (mism_count),
    .error          (error),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .last_data      (last_data),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset stimulus: assert for a few cycles, release on a falling edge
  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive n beats, holding in_valid; each waits (bounded) for in_ready
  task automatic send_beats(input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    bit         got;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < n; i++) begin
      in_data  = d[i];
      in_valid = 1'b1;
      got      = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (in_ready === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        tests++; failed++;
        $display("FAIL send_timeout beat=%0d in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b0)     begin failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if (rx_count !== 3'd0)     begin failed++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
    tests++; if (mism_count !== 3'd0)   begin failed++; $display("FAIL reset_mism_count got=%0d exp=0", mism_count); end
    tests++; if (error !== 1'b0)        begin failed++; $display("FAIL reset_error got=%b exp=0", error); end
    tests++; if (first_err_idx !== 3'd0) begin failed++; $display("FAIL reset_first_err_idx got=%0d exp=0", first_err_idx); end
    tests++; if (first_err_data !== 8'h00) begin failed++; $display("FAIL reset_first_err_data got=%h exp=00", first_err_data); end
    tests++; if (last_data !== 8'h00)   begin failed++; $display("FAIL reset_last_data got=%h exp=00", last_data); end
    tests++; if (done !== 1'b0)         begin failed++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SINK_STALL_EN
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL first_edge_in_ready got=%b exp=0", in_ready); end
`else
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL first_edge_in_ready got=%b exp=1", in_ready); end
`endif
  endtask

`ifndef SINK_STALL_EN
  // Four correct beats on consecutive edges
  task automatic test_back_to_back();
    logic [7:0] exp_d;
    do_reset();
    @(posedge clk); #1;
    exp_d = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = exp_d;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      tests++; if (rx_count !== 3'(i + 1)) begin failed++; $display("FAIL b2b_rx_count beat=%0d got=%0d exp=%0d", i, rx_count, i + 1); end
      exp_d = exp_d + 8'h11;
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (done !== 1'b1)        begin failed++; $display("FAIL b2b_done got=%b exp=1", done); end
    tests++; if (rx_count !== 3'd4)    begin failed++; $display("FAIL b2b_rx_final got=%0d exp=4", rx_count); end
    tests++; if (error !== 1'b0)       begin failed++; $display("FAIL b2b_error got=%b exp=0", error); end
    tests++; if (mism_count !== 3'd0)  begin failed++; $display("FAIL b2b_mism got=%0d exp=0", mism_count); end
    tests++; if (last_data !== 8'h44)  begin failed++; $display("FAIL b2b_last_data got=%h exp=44", last_data); end
    tests++; if (in_ready !== 1'b0)    begin failed++; $display("FAIL b2b_ready_after got=%b exp=0", in_ready); end
  endtask
`else
  // Pattern 1011_0110 with in_valid held: accepts on edges 3,4,6,7
  task automatic test_stall();
    logic [2:0] exp_rx [9];
    exp_rx = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      tests++; if (rx_count !== exp_rx[e]) begin failed++; $display("FAIL stall_rx edge=%0d got=%0d exp=%0d", e, rx_count, exp_rx[e]); end
      in_data = 8'h11 * (8'(rx_count) + 8'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (done !== 1'b1)       begin failed++; $display("FAIL stall_done got=%b exp=1", done); end
    tests++; if (error !== 1'b0)      begin failed++; $display("FAIL stall_error got=%b exp=0", error); end
    tests++; if (last_data !== 8'h44) begin failed++; $display("FAIL stall_last got=%h exp=44", last_data); end
  endtask
`endif

  task automatic test_single_error();
    do_reset();
    send_beats(4, 8'h11, 8'h22, 8'h35, 8'h44);
    @(negedge clk);
    tests++; if (error !== 1'b1)          begin failed++; $display("FAIL err1_error got=%b exp=1", error); end
    tests++; if (mism_count !== 3'd1)     begin failed++; $display("FAIL err1_mism got=%0d exp=1", mism_count); end
    tests++; if (first_err_idx !== 3'd2)  begin failed++; $display("FAIL err1_idx got=%0d exp=2", first_err_idx); end
    tests++; if (first_err_data !== 8'h35) begin failed++; $display("FAIL err1_data got=%h exp=35", first_err_data); end
    tests++; if (done !== 1'b1)           begin failed++; $display("FAIL err1_done got=%b exp=1", done); end
    tests++; if (rx_count !== 3'd4)       begin failed++; $display("FAIL err1_rx got=%0d exp=4", rx_count); end
  endtask

  task automatic test_two_errors();
    do_reset();
    send_beats(4, 8'h11, 8'h00, 8'h33, 8'hFF);
    @(negedge clk);
    tests++; if (mism_count !== 3'd2)     begin failed++; $display("FAIL err2_mism got=%0d exp=2", mism_count); end
    tests++; if (first_err_idx !== 3'd1)  begin failed++; $display("FAIL err2_idx got=%0d exp=1", first_err_idx); end
    tests++; if (first_err_data !== 8'h00) begin failed++; $display("FAIL err2_data got=%h exp=00", first_err_data); end
    tests++; if (last_data !== 8'hFF)     begin failed++; $display("FAIL err2_last got=%h exp=FF", last_data); end
    tests++; if (error !== 1'b1)          begin failed++; $display("FAIL err2_error got=%b exp=1", error); end
  endtask

  // Reset pulsed while clk is high, away from any edge
  task automatic test_mid_reset();
    do_reset();
    send_beats(2, 8'h11, 8'h00, 8'h00, 8'h00);
    tests++; if (rx_count !== 3'd2) begin failed++; $display("FAIL midrst_pre_rx got=%0d exp=2", rx_count); end
    tests++; if (mism_count !== 3'd1) begin failed++; $display("FAIL midrst_pre_mism got=%0d exp=1", mism_count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (rx_count !== 3'd0)     begin failed++; $display("FAIL midrst_rx got=%0d exp=0", rx_count); end
    tests++; if (mism_count !== 3'd0)   begin failed++; $display("FAIL midrst_mism got=%0d exp=0", mism_count); end
    tests++; if (error !== 1'b0)        begin failed++; $display("FAIL midrst_error got=%b exp=0", error); end
    tests++; if (first_err_idx !== 3'd0) begin failed++; $display("FAIL midrst_idx got=%0d exp=0", first_err_idx); end
    tests++; if (first_err_data !== 8'h00) begin failed++; $display("FAIL midrst_errdata got=%h exp=00", first_err_data); end
    tests++; if (last_data !== 8'h00)   begin failed++; $display("FAIL midrst_last got=%h exp=00", last_data); end
    tests++; if (in_ready !== 1'b0)     begin failed++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send_beats(4, 8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    tests++; if (rx_count !== 3'd4) begin failed++; $display("FAIL midrst_fresh_rx got=%0d exp=4", rx_count); end
    tests++; if (error !== 1'b0)    begin failed++; $display("FAIL midrst_fresh_error got=%b exp=0", error); end
    tests++; if (done !== 1'b1)     begin failed++; $display("FAIL midrst_fresh_done got=%b exp=1", done); end
  endtask

  // Runs after a clean completion (last_data 44, mism 0)
  task automatic test_after_done();
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL done_ready cyc=%0d got=%b exp=0", c, in_ready); end
    end
    in_valid = 1'b0;
    tests++; if (rx_count !== 3'd4)   begin failed++; $display("FAIL done_rx got=%0d exp=4", rx_count); end
    tests++; if (last_data !== 8'h44) begin failed++; $display("FAIL done_last got=%h exp=44", last_data); end
    tests++; if (mism_count !== 3'd0) begin failed++; $display("FAIL done_mism got=%0d exp=0", mism_count); end
    tests++; if (done !== 1'b1)       begin failed++; $display("FAIL done_sticky got=%b exp=1", done); end
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
`ifndef SINK_STALL_EN
    test_back_to_back();
`else
    test_stall();
`endif
    test_single_error();
    test_two_errors();
    test_mid_reset();
    test_after_done();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
